// File: rtl/qwave_pkg.sv
// Shared types and helpers for the quarter-wave DDS: quadrant encoding,
// table-address mirroring and the offset-binary midpoint.
package qwave_pkg;

   typedef enum logic [1:0] {
      Q_RISE     = 2'd0,
      Q_FALL     = 2'd1,
      Q_NEG_FALL = 2'd2,
      Q_NEG_RISE = 2'd3
   } quadrant_e;

   // Offset-binary zero point for a table of the given sample width.
   function automatic int unsigned mid_value(input int unsigned sample_width);
      return 32'd1 << sample_width;
   endfunction

   // Quadrants that walk the table backwards read (2^aw - 1) - addr.
   function automatic logic [31:0] mirror_addr(input logic [31:0] addr,
                                               input int unsigned addr_width);
      return ((32'd1 << addr_width) - 32'd1) - addr;
   endfunction

   function automatic logic is_mirrored(input quadrant_e q);
      return (q == Q_FALL) || (q == Q_NEG_RISE);
   endfunction

   function automatic logic is_positive(input quadrant_e q);
      return (q == Q_RISE) || (q == Q_FALL);
   endfunction

endpackage

// File: rtl/qwave_rom.sv
// Quarter-wave sample table: registered single-port read, shaped for
// block-RAM inference.
module qwave_rom
   import qwave_pkg::*;
#(
   parameter string INIT_FILE    = "",
   parameter int    ADDR_WIDTH   = 7,
   parameter int    SAMPLE_WIDTH = 9
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic [SAMPLE_WIDTH-1:0] o_data
);

   logic [SAMPLE_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
   logic [SAMPLE_WIDTH-1:0] r_data;

   // NOTE: the table itself is never reset; only the read register is, which keeps it mappable to block RAM.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_data <= '0;
      else       r_data <= r_mem[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/quarter_wave_dds.sv
// Phase-accumulator tone generator reconstructing a full sine period from a
// quarter-wave table. Define QWAVE_SIGNED_OUT_EN for two's-complement output.
module quarter_wave_dds
   import qwave_pkg::*;
#(
   parameter string INIT_FILE    = "",
   parameter int    ADDR_WIDTH   = 7,
   parameter int    SAMPLE_WIDTH = 9,
   parameter int    PHASE_WIDTH  = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_en,
   input  logic                   i_phase_clear,
   input  logic [PHASE_WIDTH-1:0] i_tuning_word,
   input  logic [PHASE_WIDTH-1:0] i_phase_offset,
   output logic [SAMPLE_WIDTH:0]  o_sample_out,
   output logic                   o_sample_valid
);

   localparam int OUT_WIDTH = SAMPLE_WIDTH + 1;
   localparam int LSB_DROP  = PHASE_WIDTH - ADDR_WIDTH - 2;
   localparam logic [OUT_WIDTH-1:0] MID = OUT_WIDTH'(mid_value(SAMPLE_WIDTH));

   logic [PHASE_WIDTH-1:0]  r_acc;
   logic [ADDR_WIDTH+1:0]   w_phase_top;
   quadrant_e               w_quadrant;
   quadrant_e               r_quadrant;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [ADDR_WIDTH-1:0]   w_rom_addr;
   logic [SAMPLE_WIDTH-1:0] w_rom_data;
   logic [1:0]              r_valid_pipe;
   logic [OUT_WIDTH-1:0]    w_sample;
   logic [OUT_WIDTH-1:0]    r_sample_out;
   logic                    r_sample_valid;

   // NOTE: clocked state is always assigned with <= so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst)              r_acc <= '0;
      else if (i_phase_clear) r_acc <= '0;
      else if (i_en)          r_acc <= r_acc + i_tuning_word;
   end

   // Only quadrant and table-address bits survive; lower phase bits are discarded.
   assign w_phase_top = (ADDR_WIDTH+2)'((r_acc + i_phase_offset) >> LSB_DROP);
   assign w_quadrant  = quadrant_e'(w_phase_top[ADDR_WIDTH+1:ADDR_WIDTH]);
   assign w_addr      = w_phase_top[ADDR_WIDTH-1:0];
   assign w_rom_addr  = is_mirrored(w_quadrant)
                      ? ADDR_WIDTH'(mirror_addr(32'(w_addr), ADDR_WIDTH))
                      : w_addr;

   qwave_rom #(
      .INIT_FILE    (INIT_FILE),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .SAMPLE_WIDTH (SAMPLE_WIDTH)
   ) u_rom (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_addr (w_rom_addr),
      .o_data (w_rom_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid_pipe <= '0;
         r_quadrant   <= Q_RISE;
      end else begin
         r_valid_pipe <= {r_valid_pipe[0], i_en};
         r_quadrant   <= w_quadrant;
      end
   end

   // NOTE: default assigned first so no path through this block can infer a latch.
   always_comb begin
      w_sample = '0;
`ifdef QWAVE_SIGNED_OUT_EN
      if (is_positive(r_quadrant)) w_sample = {1'b0, w_rom_data};
      else                         w_sample = {1'b1, ~w_rom_data};
`else
      if (is_positive(r_quadrant)) w_sample = MID + OUT_WIDTH'(w_rom_data);
      else                         w_sample = MID - OUT_WIDTH'(1) - OUT_WIDTH'(w_rom_data);
`endif
   end

   // Output holds its last sample whenever no new one arrives.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sample_out   <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample_valid <= r_valid_pipe[1];
         if (r_valid_pipe[1]) r_sample_out <= w_sample;
      end
   end

   assign o_sample_out   = r_sample_out;
   assign o_sample_valid = r_sample_valid;

endmodule

// File: tb/tb_quarter_wave_dds.sv
// Self-checking bench for quarter_wave_dds with table m[i] = 4*i; the expected
// stream comes from a cycle-indexed history and a direct phase-to-sample formula.
module tb_quarter_wave_dds;

   localparam int PW = 16;
   localparam int AW = 7;
   localparam int SW = 9;
   localparam int HN = 4096;

`ifdef QWAVE_SIGNED_OUT_EN
   localparam int RAMP_FIRST = 4;
   localparam int WRAP_A     = 1023;
   localparam int WRAP_B     = 0;
   localparam int QEXP [4]   = '{0, 508, 1023, 515};
`else
   localparam int RAMP_FIRST = 516;
   localparam int WRAP_A     = 511;
   localparam int WRAP_B     = 512;
   localparam int QEXP [4]   = '{512, 1020, 511, 3};
`endif
   localparam int QOFF [4]   = '{'h0000, 'h4000, 'h8000, 'hC000};

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          clr;
   logic [PW-1:0] tw;
   logic [PW-1:0] off;
   logic [SW:0]   sample_out;
   logic          sample_valid;

   always #5 clk = ~clk;

   quarter_wave_dds #(
      .INIT_FILE    (""),
      .ADDR_WIDTH   (AW),
      .SAMPLE_WIDTH (SW),
      .PHASE_WIDTH  (PW)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_en           (en),
      .i_phase_clear  (clr),
      .i_tuning_word  (tw),
      .i_phase_offset (off),
      .o_sample_out   (sample_out),
      .o_sample_valid (sample_valid)
   );

   int checks = 0;
   int errors = 0;

   bit h_en  [HN];
   bit h_rst [HN];
   int h_acc [HN];
   int h_off [HN];
   int cyc = 0;
   int m_acc = 0;
   int exp_out = 0;
   bit exp_valid = 1'b0;

   // Full-period sine sample for a 16-bit phase, straight from the quadrant rules.
   function automatic int ref_sample(input int phase);
      int p, q, idx, m;
      p   = phase % 65536;
      q   = p / 16384;
      idx = (p % 16384) / 128;
      if (q == 1 || q == 3) idx = 127 - idx;
      m = 4 * idx;
`ifdef QWAVE_SIGNED_OUT_EN
      return (q < 2) ? m : 1023 - m;
`else
      return (q < 2) ? 512 + m : 511 - m;
`endif
   endfunction

   // One clock: apply inputs, record history at the edge, derive expectations, settle on negedge.
   task automatic drive(input bit r, input bit e, input bit c, input int t, input int o);
      rst = r; en = e; clr = c; tw = t[15:0]; off = o[15:0];
      @(posedge clk);
      h_rst[cyc] = r;
      h_en[cyc]  = e && !r;
      h_off[cyc] = o;
      if (r || c)  m_acc = 0;
      else if (e)  m_acc = (m_acc + t) % 65536;
      h_acc[cyc] = m_acc;
      exp_valid = 1'b0;
      if (cyc >= 2) begin
         if (h_en[cyc-2] && !h_rst[cyc-1] && !r) exp_valid = 1'b1;
      end
      if (exp_valid) exp_out = ref_sample(h_acc[cyc-2] + h_off[cyc-1]);
      else if (r)    exp_out = 0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      checks++;
      if (sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", sample_valid);
      end
      checks++;
      if (sample_out !== 10'd0) begin
         errors++;
         $display("FAIL reset_out: got %0d expected 0", sample_out);
      end
   endtask

   task automatic test_ramp();
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 0, 128, 0);
         if (i >= 2) begin
            checks++;
            if (sample_valid !== 1'b1 || sample_out !== 10'(RAMP_FIRST + 4 * (i - 2))) begin
               errors++;
               $display("FAIL ramp[%0d]: got valid=%b out=%0d expected valid=1 out=%0d",
                        i, sample_valid, sample_out, RAMP_FIRST + 4 * (i - 2));
            end
         end
      end
   endtask

   task automatic test_quadrants();
      for (int q = 0; q < 4; q++) begin
         drive(0, 1, 1, 0, QOFF[q]);
         drive(0, 0, 0, 0, QOFF[q]);
         drive(0, 0, 0, 0, QOFF[q]);
         checks++;
         if (sample_valid !== 1'b1 || sample_out !== 10'(QEXP[q])) begin
            errors++;
            $display("FAIL quadrant_off_%h: got valid=%b out=%0d expected valid=1 out=%0d",
                     QOFF[q], sample_valid, sample_out, QEXP[q]);
         end
      end
   endtask

   task automatic test_wrap();
      drive(0, 0, 1, 0, 0);
      drive(0, 1, 0, 'hFF80, 0);
      drive(0, 1, 0, 128, 0);
      drive(0, 0, 0, 0, 0);
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== 10'(WRAP_A)) begin
         errors++;
         $display("FAIL wrap_pre: got valid=%b out=%0d expected valid=1 out=%0d",
                  sample_valid, sample_out, WRAP_A);
      end
      drive(0, 0, 0, 0, 0);
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== 10'(WRAP_B)) begin
         errors++;
         $display("FAIL wrap_post: got valid=%b out=%0d expected valid=1 out=%0d",
                  sample_valid, sample_out, WRAP_B);
      end
      checks++;
      if (m_acc != 0) begin
         errors++;
         $display("FAIL wrap_acc_model: got %0d expected 0", m_acc);
      end
   endtask

   task automatic test_gap();
      bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int t;
      t = int'($urandom_range(1, 65535));
      for (int i = 0; i < 6; i++) begin
         drive(0, pat[i], 0, t, 0);
         if (i >= 2) begin
            checks++;
            if (sample_valid !== pat[i-2]) begin
               errors++;
               $display("FAIL gap_valid[%0d]: got %b expected %b", i, sample_valid, pat[i-2]);
            end
            checks++;
            if (sample_out !== 10'(exp_out)) begin
               errors++;
               $display("FAIL gap_out[%0d]: got %0d expected %0d", i, sample_out, exp_out);
            end
         end
      end
   endtask

   task automatic test_reset_inflight();
      drive(0, 1, 0, 777, 0);
      drive(0, 1, 0, 777, 0);
      drive(1, 1, 0, 777, 0);
      checks++;
      if (sample_valid !== 1'b0 || sample_out !== 10'd0) begin
         errors++;
         $display("FAIL inflight_reset: got valid=%b out=%0d expected valid=0 out=0",
                  sample_valid, sample_out);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0);
         checks++;
         if (sample_valid !== 1'b0 || sample_out !== 10'd0) begin
            errors++;
            $display("FAIL inflight_stale[%0d]: got valid=%b out=%0d expected valid=0 out=0",
                     i, sample_valid, sample_out);
         end
      end
   endtask

   task automatic test_random();
      int o;
      o = 0;
      for (int i = 0; i < 400; i++) begin
         bit r, e, c;
         r = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 99) < 75);
         c = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 9) == 0) o = int'($urandom_range(0, 65535));
         drive(r, e, c, int'($urandom_range(0, 65535)), o);
         checks++;
         if (sample_valid !== exp_valid || sample_out !== 10'(exp_out)) begin
            errors++;
            $display("FAIL random[%0d]: got valid=%b out=%0d expected valid=%b out=%0d",
                     i, sample_valid, sample_out, exp_valid, exp_out);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) dut.u_rom.r_mem[i] = 9'(4 * i);
      test_reset();
      test_ramp();
      test_quadrants();
      test_wrap();
      test_gap();
      test_reset_inflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
